// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: width/vector defaults, next-PC source
// encoding and the PC unit's sequencing states.
package riscv_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_JALR,
        SEL_JAL,
        SEL_BR,
        SEL_SEQ,
        SEL_HOLD
    } pc_sel_e;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/pc_target_sel.sv
// Next-PC source priority (trap > stall > jalr > jal > branch > seq), target adders
// and alignment check; purely combinational, misaligned control targets divert to TRAP_VEC.
module pc_target_sel
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF),
    parameter int              IALIGN   = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            trap,
    input  logic            jalr,
    input  logic            jal,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output pc_sel_e         sel,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] rel_tgt;
    logic [XLEN-1:0] seq_tgt;

    assign jalr_sum = rs1 + imm;
    assign jalr_tgt = jalr_sum & ~XLEN'(1);
    assign rel_tgt  = pc + imm;
    assign seq_tgt  = pc + XLEN'(4);

    // trap outranks stall so a held pipeline can still be redirected
    always_comb begin
        sel = SEL_SEQ;
        if (trap)              sel = SEL_TRAP;
        else if (stall)        sel = SEL_HOLD;
        else if (jalr)         sel = SEL_JALR;
        else if (jal)          sel = SEL_JAL;
        else if (branch_taken) sel = SEL_BR;
    end

    always_comb begin
        target = seq_tgt;
        case (sel)
            SEL_TRAP: target = TRAP_VEC;
            SEL_HOLD: target = pc;
            SEL_JALR: target = jalr_tgt;
            SEL_JAL:  target = rel_tgt;
            SEL_BR:   target = rel_tgt;
            default:  target = seq_tgt;
        endcase
    end

    assign misalign = ((sel == SEL_JALR) || (sel == SEL_JAL) || (sel == SEL_BR))
                      && ((target & ALIGN_MASK) != '0);
    assign next_pc  = misalign ? TRAP_VEC : target;

endmodule

// File: rtl/pc_next_unit.sv
// Program counter register with boot sequencing, misaligned-target fault capture
// and an advance counter; redirects appear on PC one cycle after being sampled.
module pc_next_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF),
    parameter int              IALIGN   = 4,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             trap,
    input  logic             Jalr,
    input  logic             Jal,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  RS1,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             fetch_valid,
    output logic             misalign,
    output logic [XLEN-1:0]  bad_target,
    output logic [CNT_W-1:0] instret
);

    state_e          state;
    state_e          state_nxt;
    logic            run;
    pc_sel_e         sel;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            tgt_misalign;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  bad_q;
    logic             mis_q;
    logic [CNT_W-1:0] cnt_q;

    pc_target_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .IALIGN   (IALIGN)
    ) u_sel (
        .pc           (pc_q),
        .stall        (stall),
        .trap         (trap),
        .jalr         (Jalr),
        .jal          (Jal),
        .branch_taken (branch_taken),
        .imm          (imm),
        .rs1          (RS1),
        .sel          (sel),
        .target       (target),
        .next_pc      (next_pc),
        .misalign     (tgt_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_RUN;
        run       = 1'b0;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                state_nxt = ST_RUN;
                run       = 1'b1;
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // BOOT ignores every redirect input, so all updates are gated by run
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
            bad_q <= '0;
            cnt_q <= '0;
        end else begin
            mis_q <= run && tgt_misalign;
            if (run) begin
                pc_q <= next_pc;
                if (tgt_misalign)     bad_q <= target;
                if (sel != SEL_HOLD)  cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign PC          = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign fetch_valid = run;
    assign misalign    = mis_q;
    assign bad_target  = bad_q;
    assign instret     = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: directed scenarios then random control mixes,
// expected outputs from a cycle-level reference model, compared by a negedge monitor.
module tb_pc_next_unit;

    localparam int          XLEN  = 32;
    localparam int          CNT_W = 6;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] TVEC  = 32'h0000_0100;
    localparam int          IAL   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stall = 1'b0;
    logic             trap = 1'b0;
    logic             Jalr = 1'b0;
    logic             Jal = 1'b0;
    logic             branch_taken = 1'b0;
    logic [XLEN-1:0]  imm = '0;
    logic [XLEN-1:0]  RS1 = '0;
    logic [XLEN-1:0]  PC;
    logic [XLEN-1:0]  pc_plus4;
    logic             fetch_valid;
    logic             misalign;
    logic [XLEN-1:0]  bad_target;
    logic [CNT_W-1:0] instret;

    pc_next_unit #(
        .XLEN(XLEN), .RESET_PC(RPC), .TRAP_VEC(TVEC), .IALIGN(IAL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .Jalr(Jalr), .Jal(Jal),
        .branch_taken(branch_taken), .imm(imm), .RS1(RS1), .PC(PC),
        .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .misalign(misalign),
        .bad_target(bad_target), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      pc4;
        logic             fv;
        logic             mis;
        logic [31:0]      bad;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [31:0]      m_pc;
    logic [31:0]      m_bad;
    logic             m_boot;
    logic             m_mis;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",          PC,                    e.pc);
            chk("pc_plus4",    pc_plus4,              e.pc4);
            chk("fetch_valid", 32'(fetch_valid),      32'(e.fv));
            chk("misalign",    32'(misalign),         32'(e.mis));
            chk("bad_target",  bad_target,            e.bad);
            chk("instret",     32'(instret),          32'(e.cnt));
        end
    end

    // One clock edge of the architectural rules, using the inputs held across it.
    task automatic model_edge();
        logic [31:0] tgt;
        bit          ctl;
        if (rst) begin
            m_pc = RPC; m_boot = 1'b1; m_mis = 1'b0; m_bad = '0; m_cnt = '0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_mis = 1'b0;
        end else if (trap) begin
            m_pc = TVEC; m_mis = 1'b0; m_cnt = m_cnt + 1'b1;
        end else if (stall) begin
            m_mis = 1'b0;
        end else begin
            ctl = 1'b1;
            if (Jalr)                     tgt = (RS1 + imm) & 32'hFFFF_FFFE;
            else if (Jal || branch_taken) tgt = m_pc + imm;
            else begin
                tgt = m_pc + 32'd4;
                ctl = 1'b0;
            end
            m_cnt = m_cnt + 1'b1;
            if (ctl && (tgt % IAL) != 0) begin
                m_bad = tgt; m_pc = TVEC; m_mis = 1'b1;
            end else begin
                m_pc = tgt; m_mis = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit t, input bit jr, input bit j,
                        input bit b, input logic [31:0] im, input logic [31:0] rs);
        rst = r; stall = s; trap = t; Jalr = jr; Jal = j; branch_taken = b;
        imm = im; RS1 = rs;
        @(posedge clk);
        #1;
        model_edge();
        exp_q.push_back('{pc: m_pc, pc4: m_pc + 32'd4, fv: !m_boot, mis: m_mis,
                          bad: m_bad, cnt: m_cnt});
    endtask

    initial begin
        logic [31:0] im;
        // reset, BOOT, then sequential 0,4,8,C,10
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0);
        // JAL with negative immediate wraps back to 0
        step(0, 0, 0, 0, 1, 0, 32'hFFFF_FFF0, 0);
        // misaligned branch target diverts to trap vector
        step(0, 0, 0, 0, 0, 1, 32'h0000_0006, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // JALR clears bit0 of the sum
        step(0, 0, 0, 1, 0, 0, 32'h0000_0005, 32'h0000_1003);
        step(0, 0, 0, 0, 1, 0, 32'h20 - m_pc, 0);
        repeat (3) step(0, 1, 0, 0, 1, 0, 32'h4, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        // trap beats a misaligned JALR target
        step(0, 0, 1, 1, 0, 0, 32'h0, 32'h0000_0002);
        step(0, 0, 0, 0, 1, 0, 32'h44 - m_pc, 0);
        step(1, 0, 1, 1, 0, 0, 32'h3, 32'h1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 800; i++) begin
            im = 32'(($urandom_range(0, 63) - 32) * 4);
            if ($urandom_range(0, 3) == 0) im = im + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) im = $urandom;
            step($urandom_range(0, 249) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 im, $urandom & 32'h0000_FFFF);
        end
        rst = 1'b0; stall = 1'b0; trap = 1'b0; Jalr = 1'b0; Jal = 1'b0; branch_taken = 1'b0;

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Program-counter register plus next-PC selection for the RISC-V core. It generalises the two-way PC/JALR target mux into a parametrised, registered unit with the following behaviour:
- five-way prioritised next-PC selection: trap, JALR, JAL, branch, sequential
- stall hold
- target-misalignment detection with fault capture
- boot sequencing
- a retired-cycle counter
It sits at the head of the datapath, feeding instruction-memory address and link-address (PC+4) to the writeback mux.

Parameters:
XLEN, 32, datapath/address width in bits (≥ 16)
RESET_PC, 32'h0000_0000, PC value loaded on reset (XLEN bits)
TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned target (XLEN bits, must be IALIGN-aligned)
IALIGN, 4, required target alignment in bytes; 4 = RV32I, 2 = compressed-capable
CNT_W, 32, width of instret counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC this cycle (pipeline/memory wait)
trap  in  1  external trap request (ecall/illegal), highest priority
Jalr  in  1  current instruction is JALR
Jal  in  1  current instruction is JAL
branch_taken  in  1  branch condition true for current instruction
imm  in  XLEN  sign-extended immediate from decoder
RS1  in  XLEN  register rs1 value (JALR base)
PC  out  XLEN  current program counter (instruction fetch address)
pc_plus4  out  XLEN  PC + 4, combinational (link address)
fetch_valid  out  1  PC is a valid fetch address this cycle
misalign  out  1  one-cycle pulse: misaligned target detected, redirected to TRAP_VEC
bad_target  out  XLEN  last misaligned target address (sticky until next fault or reset)
instret  out  CNT_W  count of cycles in which PC advanced

Behaviour:
- Reset (rst=1 at edge):
  - PC=RESET_PC, state=BOOT, fetch_valid=0, misalign=0, bad_target=0, instret=0.
  - Reset wins over every other input, including mid-stall and mid-trap.
- FSM states:
  - BOOT: exactly one cycle after reset release; PC holds RESET_PC, fetch_valid=0, all redirect inputs ignored; unconditionally goes to RUN.
  - RUN: fetch_valid=1; stays in RUN until reset.
- Target computation (XLEN-bit, wrap-around modulo 2^XLEN, no overflow flag):
  - jalr_tgt = (RS1 + imm) with bit0 forced to 0
  - pc_rel_tgt = PC + imm
  - seq = PC + 4
- Next-PC priority in RUN, evaluated combinationally and registered at the edge:
  1. trap -> TRAP_VEC; applies even when stall=1.
  2. stall -> PC holds; Jalr/Jal/branch_taken ignored.
  3. Jalr -> jalr_tgt.
  4. Jal -> pc_rel_tgt.
  5. branch_taken -> pc_rel_tgt.
  6. Otherwise -> seq.
- Misalignment check, applied to the selected target from rules 3–5 only:
  - misaligned if target mod IALIGN ≠ 0 (IALIGN=4: bits[1:0]≠0; IALIGN=2: bit0≠0, never true for JALR).
  - On misalign: next PC=TRAP_VEC, bad_target<=target, misalign=1 for exactly the following cycle.
  - trap and misalign in the same cycle: trap wins, bad_target unchanged, misalign=0.
- Multiple control inputs asserted at once: resolved strictly by the priority above. Decoder misuse is not flagged.
- instret:
  - increments by 1 on every RUN edge where PC changes source (not stall, not BOOT), including trap redirects.
  - wraps from all-ones to 0.
- Latency: redirect visible on PC one cycle after the inputs are sampled; pc_plus4 tracks PC with zero latency.

Decomposition:
- Shared package (riscv_pkg) holds:
  - XLEN default
  - RESET_PC/TRAP_VEC defaults
  - pc_sel encoding: SEL_TRAP, SEL_JALR, SEL_JAL, SEL_BR, SEL_SEQ, SEL_HOLD
  - FSM state encoding: ST_BOOT, ST_RUN
- One sub-module, pc_target_sel: combinational priority encoder plus target adders plus alignment check; outputs the selected next PC and the misalign flag.
- The top level holds the PC register, FSM, fault capture and counter.

Test Plan:
- Reset then release with no controls, RESET_PC=0: cycle 1 PC=0 fetch_valid=0; then PC=0 with fetch_valid=1, then 4, 8; instret=2 after two advances.
- Jalr=1, RS1=32'h0000_1003, imm=32'h0000_0005 -> next PC=32'h0000_1008 (bit0 cleared; 0x1008 is aligned), misalign=0.
- Jal=1 at PC=32'h10, imm=32'hFFFF_FFF0 -> PC=0 (wrap via negative imm); branch_taken=1, imm=32'h6 at PC=0 -> PC=TRAP_VEC=0x100, misalign pulses 1 cycle, bad_target=32'h6.
- stall=1 with Jal=1 for 3 cycles at PC=0x20 -> PC stays 0x20, instret unchanged; stall=1 with trap=1 -> PC=0x100.
- trap=1 and Jalr=1 with misaligned jalr_tgt -> PC=0x100, misalign=0, bad_target keeps previous value.
- rst asserted mid-sequence while PC=0x44 -> next edge PC=RESET_PC, instret=0, bad_target=0, BOOT cycle repeats.
